// File: rtl/vjtag_avmm_bridge_if.sv
// Bus bundle between the VJTAG host controller, the bridge and the Avalon-MM
// interconnect. The "slave" modport is the bridge's view: it receives host
// requests and masters the Avalon side. The "master" modport is the opposite
// view, used by whatever drives the host requests and models the Avalon slave.
interface vjtag_avmm_bridge_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    // Host controller side
    logic [AW-1:0] address;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready;
    logic          rvalid;
    logic          rready;
    logic          rrvalid;
    logic [DW-1:0] rdata;
    // Avalon-MM side
    logic [AW-1:0] avm_address;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_read;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;
    logic          avm_readdatavalid;
    // Error status
    logic          clr_err;
    logic          timeout_err;

    modport slave (
        input  address, wvalid, wdata, rvalid,
        output wready, rready, rrvalid, rdata,
        output avm_address, avm_write, avm_writedata, avm_read,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid,
        input  clr_err,
        output timeout_err
    );

    modport master (
        output address, wvalid, wdata, rvalid,
        input  wready, rready, rrvalid, rdata,
        input  avm_address, avm_write, avm_writedata, avm_read,
        output avm_readdata, avm_waitrequest, avm_readdatavalid,
        output clr_err,
        input  timeout_err
    );
endinterface

// File: rtl/vjtag_avmm_bridge.sv
// Turns single host-controller bus requests into single Avalon-MM transfers,
// one outstanding at a time, with a timeout so a hung slave cannot stall the
// JTAG host: an aborted read still returns ERR_DATA.
module vjtag_avmm_bridge #(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter int            TIMEOUT  = 255,
    parameter logic [DW-1:0] ERR_DATA = {DW{1'b1}}
) (
    input logic                clk,
    input logic                rst_n,
    vjtag_avmm_bridge_if.slave bus
);

    // Counter is at least one bit wide so TIMEOUT=0 (disabled) still elaborates.
    localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
    localparam bit            TO_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_REQ  = 2'd2,
        READ_WAIT = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] avm_address_q;
    logic [DW-1:0] avm_writedata_q;
    logic          avm_write_q;
    logic          avm_read_q;
    logic          rrvalid_q;
    logic [DW-1:0] rdata_q;
    logic          timeout_err_q;
    logic          timeout_hit_d;

    // Acceptance is combinational in IDLE; a write always beats a read.
    assign bus.wready = (state_q == IDLE) & bus.wvalid;
    assign bus.rready = (state_q == IDLE) & bus.rvalid & ~bus.wvalid;

    assign bus.avm_address   = avm_address_q;
    assign bus.avm_writedata = avm_writedata_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.rrvalid       = rrvalid_q;
    assign bus.rdata         = rdata_q;
    assign bus.timeout_err   = timeout_err_q;

    // Timeout fires in the cycle the per-state counter reaches TIMEOUT.
    always_comb begin
        timeout_hit_d = TO_EN && (cnt_q == TO_VAL);
    end

    // Transfer FSM; a normal completion takes priority over a coincident timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_q     <= 1'b0;
            avm_read_q      <= 1'b0;
            rrvalid_q       <= 1'b0;
            rdata_q         <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            rrvalid_q <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (bus.clr_err) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.wvalid) begin
                        avm_address_q   <= bus.address;
                        avm_writedata_q <= bus.wdata;
                        avm_write_q     <= 1'b1;
                        state_q         <= WRITE;
                    end else if (bus.rvalid) begin
                        avm_address_q <= bus.address;
                        avm_read_q    <= 1'b1;
                        state_q       <= READ_REQ;
                    end
                end
                WRITE: begin
                    if (!bus.avm_waitrequest) begin
                        avm_write_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end else if (timeout_hit_d) begin
                        avm_write_q   <= 1'b0;
                        cnt_q         <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                READ_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        cnt_q      <= '0;
                        if (bus.avm_readdatavalid) begin
                            rdata_q   <= bus.avm_readdata;
                            rrvalid_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= READ_WAIT;
                        end
                    end else if (timeout_hit_d) begin
                        avm_read_q    <= 1'b0;
                        cnt_q         <= '0;
                        rdata_q       <= ERR_DATA;
                        rrvalid_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                READ_WAIT: begin
                    if (bus.avm_readdatavalid) begin
                        rdata_q   <= bus.avm_readdata;
                        rrvalid_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (timeout_hit_d) begin
                        rdata_q       <= ERR_DATA;
                        rrvalid_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vjtag_avmm_bridge.sv
// Directed bench for vjtag_avmm_bridge with TIMEOUT=4. Inputs change 2 time
// units after each rising edge; outputs are checked 1 unit later, so every
// check observes one well-defined clock cycle.
module tb_vjtag_avmm_bridge;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    vjtag_avmm_bridge_if #(.AW(8), .DW(8)) bus ();

    vjtag_avmm_bridge #(
        .AW      (8),
        .DW      (8),
        .TIMEOUT (4),
        .ERR_DATA(8'hFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n                 = 1'b0;
        bus.address           = '0;
        bus.wvalid            = 1'b0;
        bus.wdata             = '0;
        bus.rvalid            = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.clr_err           = 1'b0;

        // Reset state
        cyc(); cyc(); cyc();
        settle();
        chk("rst_wready",  32'(bus.wready), 0);
        chk("rst_rready",  32'(bus.rready), 0);
        chk("rst_rrvalid", 32'(bus.rrvalid), 0);
        chk("rst_rdata",   32'(bus.rdata), 0);
        chk("rst_addr",    32'(bus.avm_address), 0);
        chk("rst_wdata",   32'(bus.avm_writedata), 0);
        chk("rst_write",   32'(bus.avm_write), 0);
        chk("rst_read",    32'(bus.avm_read), 0);
        chk("rst_terr",    32'(bus.timeout_err), 0);
        rst_n = 1'b1;

        // Write, no stall
        cyc();
        bus.address = 8'h12; bus.wdata = 8'hA5; bus.wvalid = 1'b1;
        settle();
        chk("w0_wready_N", 32'(bus.wready), 1);
        chk("w0_rready_N", 32'(bus.rready), 0);
        cyc();
        bus.wvalid = 1'b0;
        settle();
        chk("w0_write_N1", 32'(bus.avm_write), 1);
        chk("w0_addr_N1",  32'(bus.avm_address), 32'h12);
        chk("w0_data_N1",  32'(bus.avm_writedata), 32'hA5);
        chk("w0_wready_N1", 32'(bus.wready), 0);
        cyc();
        settle();
        chk("w0_write_N2",   32'(bus.avm_write), 0);
        chk("w0_rrvalid_N2", 32'(bus.rrvalid), 0);

        // Write with 3 cycles of waitrequest; a second write waits for IDLE
        cyc();
        bus.address = 8'h34; bus.wdata = 8'h5A; bus.wvalid = 1'b1;
        bus.avm_waitrequest = 1'b1;
        settle();
        chk("w3_wready_N", 32'(bus.wready), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.wvalid = 1'b0;
            if (i >= 1) begin
                bus.address = 8'h56; bus.wdata = 8'h11; bus.wvalid = 1'b1;
            end
            bus.avm_waitrequest = (i < 3);
            settle();
            chk($sformatf("w3_write_%0d", i),  32'(bus.avm_write), 1);
            chk($sformatf("w3_addr_%0d", i),   32'(bus.avm_address), 32'h34);
            chk($sformatf("w3_data_%0d", i),   32'(bus.avm_writedata), 32'h5A);
            chk($sformatf("w3_wready_%0d", i), 32'(bus.wready), 0);
        end
        cyc();
        bus.avm_waitrequest = 1'b0;
        settle();
        chk("w3_write_idle",  32'(bus.avm_write), 0);
        chk("w3_wready_idle", 32'(bus.wready), 1);
        cyc();
        bus.wvalid = 1'b0;
        settle();
        chk("w3b_write", 32'(bus.avm_write), 1);
        chk("w3b_addr",  32'(bus.avm_address), 32'h56);
        chk("w3b_data",  32'(bus.avm_writedata), 32'h11);
        cyc();
        settle();
        chk("w3b_write_end", 32'(bus.avm_write), 0);
        chk("w3b_terr",      32'(bus.timeout_err), 0);

        // Read with readdatavalid latency 2
        cyc();
        bus.address = 8'h40; bus.rvalid = 1'b1;
        settle();
        chk("r2_rready_N", 32'(bus.rready), 1);
        chk("r2_wready_N", 32'(bus.wready), 0);
        cyc();
        bus.rvalid = 1'b0;
        settle();
        chk("r2_read_N1", 32'(bus.avm_read), 1);
        chk("r2_addr_N1", 32'(bus.avm_address), 32'h40);
        cyc();
        settle();
        chk("r2_read_N2",    32'(bus.avm_read), 0);
        chk("r2_rrvalid_N2", 32'(bus.rrvalid), 0);
        cyc();
        bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 8'h3C;
        settle();
        chk("r2_rrvalid_N3", 32'(bus.rrvalid), 0);
        cyc();
        bus.avm_readdatavalid = 1'b0; bus.avm_readdata = 8'h00;
        settle();
        chk("r2_rrvalid_N4", 32'(bus.rrvalid), 1);
        chk("r2_rdata_N4",   32'(bus.rdata), 32'h3C);
        cyc();
        settle();
        chk("r2_rrvalid_N5", 32'(bus.rrvalid), 0);

        // Simultaneous write and read: write first, read on the next IDLE cycle
        cyc();
        bus.address = 8'h77; bus.wdata = 8'h99; bus.wvalid = 1'b1; bus.rvalid = 1'b1;
        settle();
        chk("wr_wready_N", 32'(bus.wready), 1);
        chk("wr_rready_N", 32'(bus.rready), 0);
        cyc();
        bus.wvalid = 1'b0; bus.address = 8'h78;
        settle();
        chk("wr_write_N1",  32'(bus.avm_write), 1);
        chk("wr_addr_N1",   32'(bus.avm_address), 32'h77);
        chk("wr_rready_N1", 32'(bus.rready), 0);
        cyc();
        settle();
        chk("wr_rready_N2", 32'(bus.rready), 1);
        chk("wr_write_N2",  32'(bus.avm_write), 0);
        cyc();
        bus.rvalid = 1'b0;
        bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 8'h21;
        settle();
        chk("wr_read_N3", 32'(bus.avm_read), 1);
        chk("wr_addr_N3", 32'(bus.avm_address), 32'h78);
        cyc();
        bus.avm_readdatavalid = 1'b0; bus.avm_readdata = 8'h00;
        settle();
        chk("wr_rrvalid_N4", 32'(bus.rrvalid), 1);
        chk("wr_rdata_N4",   32'(bus.rdata), 32'h21);
        chk("wr_read_N4",    32'(bus.avm_read), 0);

        // Read timeout: 5 cycles in READ_WAIT, then ERR_DATA response
        cyc();
        bus.address = 8'h50; bus.rvalid = 1'b1;
        settle();
        chk("to_rready_N", 32'(bus.rready), 1);
        cyc();
        bus.rvalid = 1'b0;
        settle();
        chk("to_read_N1", 32'(bus.avm_read), 1);
        for (int i = 2; i <= 6; i++) begin
            cyc();
            settle();
            chk($sformatf("to_rrvalid_N%0d", i), 32'(bus.rrvalid), 0);
            chk($sformatf("to_terr_N%0d", i),    32'(bus.timeout_err), 0);
        end
        cyc();
        settle();
        chk("to_rrvalid_N7", 32'(bus.rrvalid), 1);
        chk("to_rdata_N7",   32'(bus.rdata), 32'hFF);
        chk("to_terr_N7",    32'(bus.timeout_err), 1);
        cyc();
        bus.clr_err = 1'b1;
        settle();
        chk("to_rrvalid_N8", 32'(bus.rrvalid), 0);
        chk("to_terr_N8",    32'(bus.timeout_err), 1);
        cyc();
        bus.clr_err = 1'b0;
        settle();
        chk("to_terr_clr", 32'(bus.timeout_err), 0);

        // Write timeout: aborted after 5 stalled cycles, no read response
        cyc();
        bus.address = 8'h0F; bus.wdata = 8'hC3; bus.wvalid = 1'b1;
        bus.avm_waitrequest = 1'b1;
        settle();
        chk("wto_wready_N", 32'(bus.wready), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            bus.wvalid = 1'b0;
            settle();
            chk($sformatf("wto_write_N%0d", i), 32'(bus.avm_write), 1);
        end
        cyc();
        settle();
        chk("wto_write_N6",   32'(bus.avm_write), 0);
        chk("wto_terr_N6",    32'(bus.timeout_err), 1);
        chk("wto_rrvalid_N6", 32'(bus.rrvalid), 0);
        cyc();
        bus.avm_waitrequest = 1'b0; bus.clr_err = 1'b1;
        settle();
        chk("wto_rrvalid_N7", 32'(bus.rrvalid), 0);
        cyc();
        bus.clr_err = 1'b0;
        settle();
        chk("wto_terr_clr", 32'(bus.timeout_err), 0);

        // Reset during READ_WAIT; late readdatavalid must be ignored
        cyc();
        bus.address = 8'h60; bus.rvalid = 1'b1;
        settle();
        chk("rr_rready_N", 32'(bus.rready), 1);
        cyc();
        bus.rvalid = 1'b0;
        settle();
        chk("rr_read_N1", 32'(bus.avm_read), 1);
        cyc();
        rst_n = 1'b0;
        settle();
        chk("rr_read_N2", 32'(bus.avm_read), 0);
        cyc();
        rst_n = 1'b1;
        bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 8'hEE;
        settle();
        chk("rr_addr_rst",    32'(bus.avm_address), 0);
        chk("rr_wdata_rst",   32'(bus.avm_writedata), 0);
        chk("rr_read_rst",    32'(bus.avm_read), 0);
        chk("rr_rrvalid_rst", 32'(bus.rrvalid), 0);
        chk("rr_rdata_rst",   32'(bus.rdata), 0);
        chk("rr_terr_rst",    32'(bus.timeout_err), 0);
        cyc();
        bus.avm_readdatavalid = 1'b0; bus.avm_readdata = 8'h00;
        settle();
        chk("rr_rrvalid_late", 32'(bus.rrvalid), 0);
        chk("rr_rdata_late",   32'(bus.rdata), 0);
        cyc();
        settle();
        chk("rr_rrvalid_end", 32'(bus.rrvalid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
